ext_bus_bridge: RTL and testbench
=================================

// Module: ext_bus_bridge
// PURPOSE
//  Parametrised external bus bridge between the CPU's EX_DM memory stage and NCH off-core
//  peripherals; generalises the single external re/we/addr port to multi-channel, wait-state
//  access. Decodes region addr[AW-1:AW-4]; region 0 is internal data memory, ignored here.
//  Each external access is held until the selected channel acks or times out. stall freezes the pipe.
// PARAMETERS
//  AW       16   address width (>=8)
//  DW       16   data width
//  NCH      4    external channels; region r (1..NCH) -> channel r-1
//  TIMEOUT  15   max wait cycles after issue before bus error (1..255)
//  ERR_DATA 16'hDEAD  read data returned on error (truncated/zero-extended to DW)
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       synchronous active-low reset
//  cpu_re     in   1       stage read request (dm_re_EX_DM)
//  cpu_we     in   1       stage write request (dm_we_EX_DM)
//  cpu_addr   in   AW      access address (dst_EX_DM)
//  cpu_wdata  in   DW      store data (p0_EX_DM)
//  cpu_rdata  out  DW      registered read data, valid in DONE
//  stall      out  1       freeze pipeline while external access outstanding
//  bus_err    out  1       sticky: timeout or unmapped region seen
//  err_clr    in   1       clears bus_err
//  ch_sel     out  NCH     one-hot channel select, high for whole BUSY
//  ch_we      out  1       1=write, 0=read (shared)
//  ch_addr    out  AW-4    offset addr[AW-5:0] (shared)
//  ch_wdata   out  DW      write data (shared)
//  ch_ack     in   NCH     per-channel completion strobe
//  ch_rdata   in   NCH*DW  per-channel read data, channel i at [i*DW +: DW]
// BEHAVIOUR
//  - One clock; reset synchronous, active-low. All outputs reset to 0; state=IDLE, counter=0.
//  - ext = (cpu_re|cpu_we) & |cpu_addr[AW-1:AW-4]. we has priority if re&we (treated as write).
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//    IDLE: if ext, latch we/addr/wdata/channel into regs and go BUSY; stall=ext (combinational).
//          unmapped region (>NCH): no ch_sel, set bus_err, go DONE with cpu_rdata=ERR_DATA.
//    BUSY: ch_sel/ch_we/ch_addr/ch_wdata driven from regs only; stall=1; cnt increments.
//          ack on selected channel: capture ch_rdata (reads) -> DONE. acks on other chans ignored.
//          cnt==TIMEOUT without ack: bus_err=1, cpu_rdata=ERR_DATA -> DONE.
//          ack on same cycle as cnt==TIMEOUT: ack wins, no error.
//    DONE: stall=0, ch_sel=0; cpu request inputs ignored (same held instr); -> IDLE next cycle.
//  - Latency: ack in k-th BUSY cycle (k>=1) => stall high k+1 cycles, DONE on cycle k+1.
//  - cpu_rdata holds value until next read completes; unchanged by writes.
//  - err_clr and new error same cycle: set wins. bus_err never cleared by transaction completion.
//  - rst_n low mid-BUSY: return to IDLE next edge, ch_sel=0, stall=0, outstanding ack discarded.
//  - Region-0 or no-request cycles: never stall, never drive ch_sel.
//  - Internal back-to-back: external access in cycle after DONE starts fresh (IDLE sees it).
// TESTING
//  1 read ch1: re=1 addr=16'h2004, ch_ack[1] after 3 cycles, rdata=16'h1234 -> stall 4 cyc,
//    ch_sel=4'b0010, ch_addr=12'h004, cpu_rdata=16'h1234 in DONE, bus_err=0.
//  2 write ch0: we=1 addr=16'h1010 wdata=16'hBEEF, ack next cycle -> ch_we=1, ch_wdata=BEEF,
//    stall 2 cyc, cpu_rdata unchanged.
//  3 timeout: read ch3 (addr 16'h4000), no ack -> stall TIMEOUT+1 cyc, cpu_rdata=16'hDEAD,
//    bus_err=1 sticky until err_clr pulse.
//  4 unmapped: re=1 addr=16'hF000 -> ch_sel stays 0, one stall cycle, rdata=DEAD, bus_err=1.
//  5 region 0: re=1 addr=16'h0100 -> stall=0, ch_sel=0 forever; ack on wrong channel during
//    BUSY of ch2 ignored, correct ch2 ack completes.
//  6 rst_n=0 in 2nd BUSY cycle -> next edge IDLE, all outputs 0; late ack produces no DONE.

Source files
------------

// File: rtl/ext_bus_bridge.sv
// External bus bridge: routes EX_DM stage accesses to NCH wait-state peripherals,
// holding the pipeline until the selected channel acks or the access times out.
module ext_bus_bridge #(
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 16,
    parameter int unsigned NCH      = 4,
    parameter int unsigned TIMEOUT  = 15,
    parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    output logic [DW-1:0]     cpu_rdata,
    output logic              stall,
    output logic              bus_err,
    input  logic              err_clr,
    output logic [NCH-1:0]    ch_sel,
    output logic              ch_we,
    output logic [AW-5:0]     ch_addr,
    output logic [DW-1:0]     ch_wdata,
    input  logic [NCH-1:0]    ch_ack,
    input  logic [NCH*DW-1:0] ch_rdata
);

    localparam logic [DW-1:0] ERR_W = DW'(ERR_DATA);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          r_state;
    logic [7:0]      r_cnt;
    logic [NCH-1:0]  r_ch_sel;
    logic            r_we;
    logic [AW-5:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_rdata;
    logic            r_bus_err;

    logic [3:0]      w_region;
    logic            w_ext;
    logic [NCH-1:0]  w_sel;
    logic            w_mapped;
    logic            w_ack;
    logic            w_timeout;
    logic            w_set_err;
    logic [DW-1:0]   w_ch_data;

    assign w_region = cpu_addr[AW-1:AW-4];
    assign w_ext    = (cpu_re | cpu_we) & (|w_region);

    always_comb begin
        w_sel = '0;
        for (int unsigned i = 0; i < NCH; i++)
            w_sel[i] = (w_region == 4'(i + 1));
    end

    assign w_mapped = |w_sel;

    // Only the latched channel can complete the access; stray acks are masked off.
    assign w_ack     = |(ch_ack & r_ch_sel);
    assign w_timeout = (r_cnt == 8'(TIMEOUT));

    always_comb begin
        w_ch_data = '0;
        for (int unsigned i = 0; i < NCH; i++)
            if (r_ch_sel[i])
                w_ch_data = w_ch_data | ch_rdata[i*DW +: DW];
    end

    assign w_set_err = ((r_state == S_IDLE) & w_ext & ~w_mapped) |
                       ((r_state == S_BUSY) & ~w_ack & w_timeout);

    assign stall     = ((r_state == S_IDLE) & w_ext) | (r_state == S_BUSY);
    assign cpu_rdata = r_rdata;
    assign bus_err   = r_bus_err;
    assign ch_sel    = r_ch_sel;
    assign ch_we     = r_we;
    assign ch_addr   = r_addr;
    assign ch_wdata  = r_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_ch_sel  <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (w_set_err)
                r_bus_err <= 1'b1;
            else if (err_clr)
                r_bus_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_ext) begin
                        r_we    <= cpu_we;
                        r_addr  <= cpu_addr[AW-5:0];
                        r_wdata <= cpu_wdata;
                        if (w_mapped) begin
                            r_ch_sel <= w_sel;
                            // Counter holds the number of the current BUSY cycle.
                            r_cnt    <= 8'd1;
                            r_state  <= S_BUSY;
                        end else begin
                            if (!cpu_we)
                                r_rdata <= ERR_W;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_BUSY: begin
                    if (w_ack) begin
                        if (!r_we)
                            r_rdata <= w_ch_data;
                        r_ch_sel <= '0;
                        r_state  <= S_DONE;
                    end else if (w_timeout) begin
                        if (!r_we)
                            r_rdata <= ERR_W;
                        r_ch_sel <= '0;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_bus_bridge.sv
// Directed bench for ext_bus_bridge: reads, writes, timeout, unmapped, region 0, reset.
module tb_ext_bus_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_re, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        stall, bus_err, err_clr;
    logic [3:0]  ch_sel;
    logic        ch_we;
    logic [11:0] ch_addr;
    logic [15:0] ch_wdata;
    logic [3:0]  ch_ack;
    logic [63:0] ch_rdata;

    int          n_tests = 0;
    int          n_fail  = 0;

    int          n_stall;
    logic [3:0]  sel_seen, sel_done;
    logic        we_seen, err_done;
    logic [11:0] addr_seen;
    logic [15:0] wd_seen, rd_done;

    ext_bus_bridge #(
        .AW(16), .DW(16), .NCH(4), .TIMEOUT(15), .ERR_DATA(16'hDEAD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .stall(stall), .bus_err(bus_err), .err_clr(err_clr),
        .ch_sel(ch_sel), .ch_we(ch_we), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_ack(ch_ack), .ch_rdata(ch_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one access and follows it to completion. ack_mask is raised in BUSY cycle
    // ack_k, bad_mask in BUSY cycle bad_k; acked channels return rd, others ~rd.
    task automatic access(input logic re, input logic we, input logic [15:0] addr,
                          input logic [15:0] wd, input int ack_k, input logic [3:0] ack_mask,
                          input int bad_k, input logic [3:0] bad_mask,
                          input logic [15:0] rd, input logic clr_first);
        int c;
        cpu_re = re; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; err_clr = clr_first;
        for (int i = 0; i < 4; i++)
            ch_rdata[i*16 +: 16] = ack_mask[i] ? rd : ~rd;
        n_stall = 0; sel_seen = '0; we_seen = 1'b0; addr_seen = '0; wd_seen = '0;
        c = 0;
        #1;
        while (stall && c < 40) begin
            n_stall++;
            c++;
            @(negedge clk);
            err_clr = 1'b0;
            if (c == 1) begin
                sel_seen = ch_sel; we_seen = ch_we; addr_seen = ch_addr; wd_seen = ch_wdata;
            end
            ch_ack = ((c == ack_k) ? ack_mask : 4'b0) | ((c == bad_k) ? bad_mask : 4'b0);
            #1;
        end
        ch_ack = '0;
        sel_done = ch_sel; rd_done = cpu_rdata; err_done = bus_err;
        cpu_re = 1'b0; cpu_we = 1'b0; err_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic clr_pulse();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        err_clr = 1'b0; ch_ack = '0; ch_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_sel", 32'(ch_sel), 32'h0);
        chk("rst_err", 32'(bus_err), 32'h0);
        chk("rst_rdata", 32'(cpu_rdata), 32'h0);
        chk("rst_we", 32'(ch_we), 32'h0);
        chk("rst_addr", 32'(ch_addr), 32'h0);
        chk("rst_wdata", 32'(ch_wdata), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // read ch1, ack in 3rd BUSY cycle
        access(1'b1, 1'b0, 16'h2004, 16'h0, 3, 4'b0010, 0, 4'b0, 16'h1234, 1'b0);
        chk("t1_stall", 32'(n_stall), 32'd4);
        chk("t1_sel", 32'(sel_seen), 32'h2);
        chk("t1_addr", 32'(addr_seen), 32'h004);
        chk("t1_we", 32'(we_seen), 32'h0);
        chk("t1_rdata", 32'(rd_done), 32'h1234);
        chk("t1_err", 32'(err_done), 32'h0);
        chk("t1_done_sel", 32'(sel_done), 32'h0);

        // write ch0, ack next cycle
        access(1'b0, 1'b1, 16'h1010, 16'hBEEF, 1, 4'b0001, 0, 4'b0, 16'h5555, 1'b0);
        chk("t2_stall", 32'(n_stall), 32'd2);
        chk("t2_sel", 32'(sel_seen), 32'h1);
        chk("t2_we", 32'(we_seen), 32'h1);
        chk("t2_wdata", 32'(wd_seen), 32'hBEEF);
        chk("t2_addr", 32'(addr_seen), 32'h010);
        chk("t2_rdata_kept", 32'(rd_done), 32'h1234);

        // re and we together behave as a write
        access(1'b1, 1'b1, 16'h2020, 16'h0A0A, 2, 4'b0010, 0, 4'b0, 16'h6666, 1'b0);
        chk("rw_stall", 32'(n_stall), 32'd3);
        chk("rw_we", 32'(we_seen), 32'h1);
        chk("rw_rdata_kept", 32'(rd_done), 32'h1234);

        // ack in the same cycle as the timeout: ack wins
        access(1'b1, 1'b0, 16'h4000, 16'h0, 15, 4'b1000, 0, 4'b0, 16'hCAFE, 1'b0);
        chk("tack_stall", 32'(n_stall), 32'd16);
        chk("tack_rdata", 32'(rd_done), 32'hCAFE);
        chk("tack_err", 32'(err_done), 32'h0);

        // timeout on ch3
        access(1'b1, 1'b0, 16'h4000, 16'h0, 0, 4'b1000, 0, 4'b0, 16'h7777, 1'b0);
        chk("t3_stall", 32'(n_stall), 32'd16);
        chk("t3_sel", 32'(sel_seen), 32'h8);
        chk("t3_rdata", 32'(rd_done), 32'hDEAD);
        chk("t3_err", 32'(err_done), 32'h1);

        // ch2 with a stray ack on other channels first; error stays sticky
        access(1'b1, 1'b0, 16'h3008, 16'h0, 2, 4'b0100, 1, 4'b1011, 16'hABCD, 1'b0);
        chk("t5_stall", 32'(n_stall), 32'd3);
        chk("t5_sel", 32'(sel_seen), 32'h4);
        chk("t5_rdata", 32'(rd_done), 32'hABCD);
        chk("t5_err_sticky", 32'(err_done), 32'h1);
        clr_pulse();
        chk("clr_err", 32'(bus_err), 32'h0);

        // unmapped region with err_clr on the same cycle: set wins
        access(1'b1, 1'b0, 16'hF000, 16'h0, 0, 4'b0, 0, 4'b0, 16'h0, 1'b1);
        chk("t4_stall", 32'(n_stall), 32'd1);
        chk("t4_sel", 32'(sel_seen), 32'h0);
        chk("t4_rdata", 32'(rd_done), 32'hDEAD);
        chk("t4_err", 32'(err_done), 32'h1);
        clr_pulse();
        chk("clr_err2", 32'(bus_err), 32'h0);

        // region 0 never stalls nor selects
        cpu_re = 1'b1; cpu_addr = 16'h0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("r0_stall", 32'(stall), 32'h0);
            chk("r0_sel", 32'(ch_sel), 32'h0);
            @(negedge clk);
        end
        cpu_re = 1'b0;
        @(negedge clk);

        // reset in 2nd BUSY cycle, late ack discarded
        cpu_re = 1'b1; cpu_addr = 16'h3000; ch_rdata = {4{16'h9999}};
        @(negedge clk);
        chk("t6_busy_sel", 32'(ch_sel), 32'h4);
        @(negedge clk);
        rst_n = 1'b0; cpu_re = 1'b0;
        @(negedge clk);
        #1;
        chk("t6_stall", 32'(stall), 32'h0);
        chk("t6_sel", 32'(ch_sel), 32'h0);
        chk("t6_rdata", 32'(cpu_rdata), 32'h0);
        chk("t6_we", 32'(ch_we), 32'h0);
        chk("t6_addr", 32'(ch_addr), 32'h0);
        rst_n = 1'b1; ch_ack = 4'b0100;
        @(negedge clk);
        ch_ack = '0;
        chk("t6_late_stall", 32'(stall), 32'h0);
        @(negedge clk);
        chk("t6_late_rdata", 32'(cpu_rdata), 32'h0);
        chk("t6_late_sel", 32'(ch_sel), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
